// File: rtl/nbody_pkg.sv
// ============================================================================
// nbody_pkg : shared types for the n-body acceleration sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package nbody_pkg;

  localparam int BODIES          = 512;
  localparam int BODY_ADDR_WIDTH = $clog2(BODIES);

  typedef logic [BODY_ADDR_WIDTH-1:0] body_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic      valid;
    logic      first;
    logic      last;
    body_idx_t i;
  } pair_tag_t;

  // Last partner index of body i: row N-1 ends at N-2 because j==i is skipped.
  function automatic body_idx_t last_j_of(input body_idx_t i, input body_idx_t n_m1);
    return (i == n_m1) ? n_m1 - body_idx_t'(1) : n_m1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_delay_line.sv
// ============================================================================
// tag_delay_line : fixed-depth shift register carrying pair tags alongside the datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module tag_delay_line
  import nbody_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  pair_tag_t din,
  output pair_tag_t dout,
  output logic      empty
);

  pair_tag_t [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (flush) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], din};
    end
  end

  assign dout = r_stage[DEPTH-1];

  // The output stage is excluded: its tag leaves on this edge, so "empty" means
  // nothing remains in flight once the current output has been presented.
  always_comb begin
    empty = 1'b1;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (r_stage[k].valid) empty = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/accel_pair_sequencer.sv
// ============================================================================
// accel_pair_sequencer : walks ordered body pairs, drives RAM reads, emits aligned tags
// Rev 1.0
// ============================================================================
`default_nettype none

module accel_pair_sequencer
  import nbody_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int ACCL_LATENCY = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
  output logic                       busy,
  output logic                       done,
  output logic [BODY_ADDR_WIDTH-1:0] rd_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_j,
  output logic                       issue,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic [BODY_ADDR_WIDTH-1:0] out_i
);

  localparam int        PIPE_LATENCY = RAM_LATENCY + ACCL_LATENCY;
  localparam body_idx_t c_ONE        = body_idx_t'(1);
  localparam body_idx_t c_TWO        = body_idx_t'(2);

  seq_state_t r_state;
  body_idx_t  r_n_m1;
  body_idx_t  r_i;
  body_idx_t  r_j;
  logic       r_issue;
  logic       r_first;
  logic       r_last;
  logic       r_busy;
  logic       r_done;

  body_idx_t  w_j_inc;
  body_idx_t  w_i_nx;
  body_idx_t  w_j_nx;
  logic       w_end_of_row;
  logic       w_final;
  logic       w_last_nx;
  pair_tag_t  w_tag_in;
  pair_tag_t  w_tag_out;
  logic       w_dl_empty;

  // Next-pair generation; the diagonal is skipped in the same cycle.
  always_comb begin
    w_end_of_row = (r_j == last_j_of(r_i, r_n_m1));
    w_final      = w_end_of_row && (r_i == r_n_m1);
    w_j_inc      = r_j + c_ONE;
    w_i_nx       = w_end_of_row ? r_i + c_ONE : r_i;
    if (w_end_of_row) begin
      w_j_nx = '0;
    end else if (w_j_inc == r_i) begin
      w_j_nx = r_j + c_TWO;
    end else begin
      w_j_nx = w_j_inc;
    end
    w_last_nx = (w_j_nx == last_j_of(w_i_nx, r_n_m1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_n_m1  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_issue <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_issue <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (num_bodies > c_ONE) begin
                r_n_m1  <= num_bodies - c_ONE;
                r_i     <= '0;
                r_j     <= c_ONE;
                r_first <= 1'b1;
                r_last  <= (num_bodies == c_TWO);
                r_issue <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= ISSUE;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (w_final) begin
              r_issue <= 1'b0;
              r_state <= DRAIN;
            end else begin
              r_i     <= w_i_nx;
              r_j     <= w_j_nx;
              r_first <= w_end_of_row;
              r_last  <= w_last_nx;
            end
          end
          DRAIN: begin
            if (w_dl_empty) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign w_tag_in = r_issue ? pair_tag_t'{valid: 1'b1, first: r_first, last: r_last, i: r_i}
                            : '0;

  tag_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   (w_tag_in),
    .dout  (w_tag_out),
    .empty (w_dl_empty)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_i      = r_i;
  assign rd_j      = r_j;
  assign issue     = r_issue;
  assign out_valid = w_tag_out.valid;
  assign out_first = w_tag_out.first;
  assign out_last  = w_tag_out.last;
  assign out_i     = w_tag_out.i;

endmodule

`default_nettype wire

// File: tb/tb_accel_pair_sequencer.sv
// ============================================================================
// tb_accel_pair_sequencer : scoreboard bench with a pair-list reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_accel_pair_sequencer;

  localparam int W    = nbody_pkg::BODY_ADDR_WIDTH;
  localparam int RAML = 1;
  localparam int ACCL = 4;
  localparam int P    = RAML + ACCL;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] num_bodies = '0;
  logic         busy, done, issue, out_valid, out_first, out_last;
  logic [W-1:0] rd_i, rd_j, out_i;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  busy_lo = 1;
  int  busy_hi = 0;
  ev_t iq[$];
  ev_t oq[$];
  int  dq[$];

  accel_pair_sequencer #(
    .RAM_LATENCY  (RAML),
    .ACCL_LATENCY (ACCL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_bodies (num_bodies),
    .busy       (busy),
    .done       (done),
    .rd_i       (rd_i),
    .rd_j       (rd_j),
    .issue      (issue),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_i      (out_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against whatever the model expects at this cycle.
  always @(negedge clk) begin
    bit  e;
    ev_t x;
    if (!rst) begin
      e = (iq.size() > 0) && (iq[0].cyc == cyc);
      chk("issue", int'(issue), int'(e));
      if (e) begin
        x = iq.pop_front();
        chk("rd_i", int'(rd_i), x.a);
        chk("rd_j", int'(rd_j), x.b);
      end
      e = (oq.size() > 0) && (oq[0].cyc == cyc);
      chk("out_valid", int'(out_valid), int'(e));
      if (e) begin
        x = oq.pop_front();
        chk("out_i", int'(out_i), x.a);
        chk("out_first", int'(out_first), x.b);
        chk("out_last", int'(out_last), x.c);
      end
      e = (dq.size() > 0) && (dq[0] == cyc);
      chk("done", int'(done), int'(e));
      if (e) void'(dq.pop_front());
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list every ordered pair, then derive tags by position in each row.
  task automatic start_pass(input int n, output int s);
    int idx;
    int js[$];
    @(negedge clk);
    num_bodies = W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      js.delete();
      for (int j = 0; j < n; j++) if (j != i) js.push_back(j);
      for (int p = 0; p < js.size(); p++) begin
        iq.push_back('{s + idx, i, js[p], 0});
        oq.push_back('{s + idx + P, i, int'(p == 0), int'(p == js.size() - 1)});
        idx++;
      end
    end
    dq.push_back((n < 2) ? s : s + idx + P);
    busy_lo = s;
    busy_hi = (n < 2) ? s - 1 : s + idx + P - 1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    iq.delete();
    oq.delete();
    dq.delete();
    if (busy_hi > cyc - 1) busy_hi = cyc - 1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (dq.size() > 0 && t < 5000) begin
      step();
      t++;
    end
    if (dq.size() > 0) begin
      chk("done_timeout", 0, 1);
      iq.delete();
      oq.delete();
      dq.delete();
    end
  endtask

  initial begin
    int s;
    int n;
    int w;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_issue", int'(issue), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_rd_i", int'(rd_i), 0);
    chk("rst_rd_j", int'(rd_j), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) step();

    start_pass(3, s); wait_idle();
    start_pass(2, s); wait_idle();
    start_pass(0, s); wait_idle();
    start_pass(1, s); wait_idle();

    // Abort on the third issue cycle, then a clean pass.
    start_pass(4, s);
    while (cyc < s + 2) step();
    do_abort();
    repeat (12) step();
    start_pass(2, s); wait_idle();

    // Start and a new body count while busy are both ignored.
    start_pass(3, s);
    repeat (3) step();
    num_bodies = W'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    repeat (3) step();

    // Abort beats start in the same cycle.
    @(negedge clk);
    num_bodies = W'(3);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (10) step();

    // Asynchronous reset during DRAIN.
    start_pass(3, s);
    while (cyc < s + 8) step();
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_done", int'(done), 0);
    iq.delete();
    oq.delete();
    dq.delete();
    busy_lo = 1;
    busy_hi = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (20) step();

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 12);
      start_pass(n, s);
      if (r % 4 == 3) begin
        w = $urandom_range(0, n * (n - 1) + P);
        repeat (w) step();
        do_abort();
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    start_pass(40, s); wait_idle();
    repeat (4) step();

    chk("leftover", iq.size() + oq.size() + dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog at cycle %0d: got running, expected finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
